pos_dac_spi: RTL and testbench
==============================

Name: pos_dac_spi

Overview:
- Downstream stage of the position PID loop.
- Takes the 16-bit PID output word `pos_dac`, optionally clamps it, and serialises it MSB-first to an external 16-bit SPI voltage-output DAC that drives the galvo amplifier.
- Controls DAC CS/SCLK/SDI and pulses LDAC so the analog output updates once per accepted sample.
- Coalesces requests: at most one frame in flight plus one pending word.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk_pid cycles; legal range 2..255.
- CLAMP_MIN, 16'h0000: lower output limit. Used only with POS_DAC_CLAMP_EN.
- CLAMP_MAX, 16'hFFFF: upper output limit. Used only with POS_DAC_CLAMP_EN. Must satisfy CLAMP_MAX >= CLAMP_MIN.

Ports:
- clk_pid  in  1  loop clock.
- sys_rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to send `pos_dac`.
- pos_dac  in  16  unsigned DAC code from the PID stage.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame fully completes.
- dac_csn  out  1  DAC chip select, active-low.
- dac_sclk  out  1  DAC serial clock, idles low.
- dac_sdi  out  1  DAC serial data.
- dac_ldacn  out  1  DAC load strobe, active-low.

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-frame): busy=0, done=0, dac_csn=1, dac_sclk=0, dac_sdi=0, dac_ldacn=1. State=IDLE, pending flag cleared, counters=0. After a mid-frame reset the DAC holds its previous code because LDAC was never pulsed.
- FSM states: IDLE, SETUP, SHIFT, LOAD, GAP.
- IDLE:
  - start=1 captures `pos_dac` into the shift register. Next cycle enters SETUP.
  - start=0: remain in IDLE.
- SETUP:
  - csn=0, sclk=0, sdi=bit15, busy=1.
  - Lasts CLK_DIV cycles.
- SHIFT:
  - 16 bits, MSB first.
  - Each bit: CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - sdi changes only at the start of a low phase. The DAC samples on the sclk rising edge.
  - After the bit0 high phase, go to LOAD.
- LOAD:
  - csn=1, sclk=0, ldacn=0.
  - Lasts CLK_DIV cycles.
- GAP:
  - ldacn=1, csn=1.
  - Lasts CLK_DIV cycles. done=1 in the final GAP cycle only.
  - Exit: to SETUP if pending is set (load the pending word, clear pending), else to IDLE.
- busy is 1 in SETUP, SHIFT, LOAD and GAP. busy falls the cycle after done when no word is pending.
- Frame length = 35*CLK_DIV cycles (140 at default).
- start while busy:
  - Writes `pos_dac` into the pending register and sets pending.
  - A later start before the frame ends overwrites it; only the newest value is kept.
  - Never aborts the current frame.
- start in the same cycle GAP exits to IDLE: treated as a new request; SETUP follows with no idle cycle.
- Counters:
  - div_cnt counts 0..CLK_DIV-1.
  - bit_cnt counts 15 down to 0; it does not wrap during SHIFT.

Optional Feature:
- Macro: POS_DAC_CLAMP_EN.
- Defined: each captured word (direct or pending) is saturated at capture. Words below CLAMP_MIN become CLAMP_MIN; words above CLAMP_MAX become CLAMP_MAX. Unsigned comparison.
- Undefined: the word is sent unmodified, and CLAMP_MIN/CLAMP_MAX are ignored.
- Frame timing is identical in both builds.

Decomposition:
- Shared package `pos_pkg`:
  - FSM state encoding type.
  - DAC word width constant (16).
  - Default CLK_DIV.
  - This package is reusable by the future ADC-capture block.
- One sub-module, `pos_dac_clamp`: combinational saturation, instantiated only under POS_DAC_CLAMP_EN.
- The FSM, counters and shift register stay in the top module.

Test Plan:
- Reset, then start with pos_dac=16'hA5C3 at CLK_DIV=4:
  - 16 rising sclk edges with sdi=1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - csn low for exactly 4+128 cycles.
  - ldacn low 4 cycles.
  - done at cycle 140; busy high cycles 1..140.
- Back-to-back:
  - start 16'h1234, then start 16'h5555 at cycle 10, then start 16'h7777 at cycle 50.
  - Exactly two frames are sent: 16'h1234, then 16'h7777.
  - The second frame's SETUP begins the cycle after the first frame's done; two done pulses total.
- start asserted in the exit cycle of GAP with 16'hFFFF: next frame begins with no idle gap and sends 16'hFFFF.
- Assert sys_rstn=0 during bit 7 of a frame:
  - Outputs immediately take idle values: csn=1, ldacn=1, sclk=0.
  - No LDAC pulse and no done.
  - After release, start 16'h0001 sends cleanly.
- With POS_DAC_CLAMP_EN, CLAMP_MIN=16'h1000, CLAMP_MAX=16'hF000:
  - Inputs 16'h0005, 16'h8000 and 16'hFFFF shift out as 16'h1000, 16'h8000 and 16'hF000.
  - Without the macro they shift out unchanged.
- CLK_DIV=2: frame length is 70 cycles, and each sclk phase lasts exactly 2 cycles.

Source files
------------

// File: rtl/pos_pkg.sv
// Shared definitions for the position loop DAC/ADC serial blocks.
// State encoding, word width and default serial clock divider.
package pos_pkg;

    localparam int DAC_W       = 16;
    localparam int CLK_DIV_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_LOAD,
        ST_GAP
    } pos_state_t;

endpackage

// File: rtl/pos_dac_clamp.sv
// Combinational saturation of a DAC code to [CLAMP_MIN, CLAMP_MAX].
// Instantiated by pos_dac_spi only when POS_DAC_CLAMP_EN is defined.
module pos_dac_clamp
    import pos_pkg::*;
#(
    parameter logic [DAC_W-1:0] CLAMP_MIN = 16'h0000,
    parameter logic [DAC_W-1:0] CLAMP_MAX = 16'hFFFF
) (
    input  logic [DAC_W-1:0] din,
    output logic [DAC_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din < CLAMP_MIN) begin
            dout = CLAMP_MIN;
        end else if (din > CLAMP_MAX) begin
            dout = CLAMP_MAX;
        end
    end

endmodule

// File: rtl/pos_dac_spi.sv
// Serialises the PID output word MSB-first to a 16-bit SPI DAC, then pulses LDAC.
// Define POS_DAC_CLAMP_EN to saturate each captured word to [CLAMP_MIN, CLAMP_MAX].
module pos_dac_spi
    import pos_pkg::*;
#(
    parameter int               CLK_DIV   = CLK_DIV_DEF,
    parameter logic [DAC_W-1:0] CLAMP_MIN = 16'h0000,
    parameter logic [DAC_W-1:0] CLAMP_MAX = 16'hFFFF
) (
    input  logic             clk_pid,
    input  logic             sys_rstn,
    input  logic             start,
    input  logic [DAC_W-1:0] pos_dac,
    output logic             busy,
    output logic             done,
    output logic             dac_csn,
    output logic             dac_sclk,
    output logic             dac_sdi,
    output logic             dac_ldacn
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_PRE  = 8'(CLK_DIV - 2);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
        $error("pos_dac_spi: CLK_DIV out of range 2..255");
    end
    if (CLAMP_MAX < CLAMP_MIN) begin : g_bad_clamp
        $error("pos_dac_spi: CLAMP_MAX below CLAMP_MIN");
    end

    pos_state_t       state;
    logic [7:0]       div_cnt;
    logic [3:0]       bit_cnt;
    logic [DAC_W-1:0] shreg;
    logic [DAC_W-1:0] pend_word;
    logic             pending;
    logic [DAC_W-1:0] cap_word;
    logic             div_last;
    logic             gap_exit;

`ifdef POS_DAC_CLAMP_EN
    pos_dac_clamp #(
        .CLAMP_MIN(CLAMP_MIN),
        .CLAMP_MAX(CLAMP_MAX)
    ) u_clamp (
        .din (pos_dac),
        .dout(cap_word)
    );
`else
    assign cap_word = pos_dac;
`endif

    assign div_last = (div_cnt == DIV_LAST);
    assign gap_exit = (state == ST_GAP) && div_last;

    always_ff @(posedge clk_pid or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            pend_word <= '0;
            pending   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dac_csn   <= 1'b1;
            dac_sclk  <= 1'b0;
            dac_sdi   <= 1'b0;
            dac_ldacn <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SETUP;
                        shreg   <= cap_word;
                        dac_sdi <= cap_word[DAC_W-1];
                        dac_csn <= 1'b0;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                    end
                end
                ST_SETUP: begin
                    if (div_last) begin
                        state   <= ST_SHIFT;
                        div_cnt <= '0;
                        bit_cnt <= 4'd15;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (!div_last) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else if (bit_cnt == 4'd0) begin
                            state     <= ST_LOAD;
                            dac_sclk  <= 1'b0;
                            dac_csn   <= 1'b1;
                            dac_ldacn <= 1'b0;
                        end else begin
                            // next bit is presented as the low phase begins
                            dac_sclk <= 1'b0;
                            bit_cnt  <= bit_cnt - 4'd1;
                            shreg    <= {shreg[DAC_W-2:0], 1'b0};
                            dac_sdi  <= shreg[DAC_W-2];
                        end
                    end
                end
                ST_LOAD: begin
                    if (div_last) begin
                        state     <= ST_GAP;
                        div_cnt   <= '0;
                        dac_ldacn <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (!div_last) begin
                        div_cnt <= div_cnt + 8'd1;
                        done    <= (div_cnt == DIV_PRE);
                    end else begin
                        div_cnt <= '0;
                        if (pending) begin
                            state   <= ST_SETUP;
                            shreg   <= pend_word;
                            dac_sdi <= pend_word[DAC_W-1];
                            dac_csn <= 1'b0;
                            pending <= 1'b0;
                        end else if (start) begin
                            state   <= ST_SETUP;
                            shreg   <= cap_word;
                            dac_sdi <= cap_word[DAC_W-1];
                            dac_csn <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            dac_sdi <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // a request while busy only updates the pending slot; newest wins
            if (start && state != ST_IDLE && !(gap_exit && !pending)) begin
                pend_word <= cap_word;
                pending   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pos_dac_spi.sv
// Directed bench for pos_dac_spi: frame timing, coalescing, reset abort, clamp, CLK_DIV=2.
// Shifted words are checked against a scoreboard queue filled when each start is driven.
`timescale 1ns/1ps
module tb_pos_dac_spi;

    logic        clk_pid = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] pos_dac = '0;
    logic [15:0] pos_dac2 = '0;
    logic        busy, done, dac_csn, dac_sclk, dac_sdi, dac_ldacn;
    logic        busy2, done2, csn2, sclk2, sdi2, ldacn2;

    int errors = 0;
    int checks = 0;
    logic [15:0] q[$];
    logic [15:0] q2[$];

    always #5 clk_pid = ~clk_pid;

    pos_dac_spi #(
        .CLK_DIV  (4),
        .CLAMP_MIN(16'h1000),
        .CLAMP_MAX(16'hF000)
    ) u_dut (
        .clk_pid  (clk_pid),
        .sys_rstn (sys_rstn),
        .start    (start),
        .pos_dac  (pos_dac),
        .busy     (busy),
        .done     (done),
        .dac_csn  (dac_csn),
        .dac_sclk (dac_sclk),
        .dac_sdi  (dac_sdi),
        .dac_ldacn(dac_ldacn)
    );

    pos_dac_spi #(
        .CLK_DIV(2)
    ) u_dut2 (
        .clk_pid  (clk_pid),
        .sys_rstn (sys_rstn),
        .start    (start2),
        .pos_dac  (pos_dac2),
        .busy     (busy2),
        .done     (done2),
        .dac_csn  (csn2),
        .dac_sclk (sclk2),
        .dac_sdi  (sdi2),
        .dac_ldacn(ldacn2)
    );

    function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef POS_DAC_CLAMP_EN
        if (w < 16'h1000) return 16'h1000;
        if (w > 16'hF000) return 16'hF000;
`endif
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_pid);
        #1;
    endtask

    // serial receivers: sample SDI on SCLK rise, pop the scoreboard on CS release
    logic [15:0] rx = '0;
    int          nbits = 0;
    always @(negedge dac_csn) nbits = 0;
    always @(posedge dac_sclk) begin
        rx = {rx[14:0], dac_sdi};
        nbits++;
    end
    always @(posedge dac_csn) begin
        if (nbits == 16) begin
            if (q.size() == 0) chk("sb_unexpected_frame", 32'(rx), 32'hDEAD);
            else chk("sb_word", 32'(rx), 32'(q.pop_front()));
        end
        nbits = 0;
    end

    logic [15:0] rx2 = '0;
    int          nbits2 = 0;
    always @(negedge csn2) nbits2 = 0;
    always @(posedge sclk2) begin
        rx2 = {rx2[14:0], sdi2};
        nbits2++;
    end
    always @(posedge csn2) begin
        if (nbits2 == 16) begin
            if (q2.size() == 0) chk("sb2_unexpected_frame", 32'(rx2), 32'hDEAD);
            else chk("sb2_word", 32'(rx2), 32'(q2.pop_front()));
        end
        nbits2 = 0;
    end

    // SCLK phase lengths on the CLK_DIV=2 instance
    int  run_len = 0, run_cnt = 0, run_min = 999, run_max = 0;
    bit  run_seen = 0;
    logic sclk2_prev = 1'b0;
    always @(negedge clk_pid) begin
        if (csn2 === 1'b0) begin
            if (sclk2 !== sclk2_prev) begin
                if (run_seen) begin
                    run_cnt++;
                    if (run_len < run_min) run_min = run_len;
                    if (run_len > run_max) run_max = run_len;
                end
                run_seen = 1;
                run_len = 1;
            end else begin
                run_len++;
            end
        end else begin
            run_seen = 0;
        end
        sclk2_prev = sclk2;
    end

    bit bh[0:511], ch[0:511], lh[0:511], dh[0:511];
    int first_busy, last_busy, n_busy, n_csn, n_ldac, n_done, done1, done2c;

    task automatic watch(input int n, input int c1, input logic [15:0] w1,
                         input int c2, input logic [15:0] w2);
        for (int c = 0; c < 512; c++) begin
            bh[c] = 0; ch[c] = 1; lh[c] = 1; dh[c] = 0;
        end
        for (int c = 1; c <= n; c++) begin
            start = (c == c1) || (c == c2);
            if (c == c1) pos_dac = w1;
            else if (c == c2) pos_dac = w2;
            bh[c] = busy; ch[c] = dac_csn; lh[c] = dac_ldacn; dh[c] = done;
            tick();
        end
        start = 1'b0;
        first_busy = -1; last_busy = -1; n_busy = 0; n_csn = 0;
        n_ldac = 0; n_done = 0; done1 = -1; done2c = -1;
        for (int c = 1; c <= n; c++) begin
            if (bh[c]) begin
                if (first_busy < 0) first_busy = c;
                last_busy = c;
                n_busy++;
            end
            if (!ch[c]) n_csn++;
            if (!lh[c]) n_ldac++;
            if (dh[c]) begin
                n_done++;
                if (done1 < 0) done1 = c;
                else if (done2c < 0) done2c = c;
            end
        end
    endtask

    task automatic send(input logic [15:0] w);
        start = 1'b1;
        pos_dac = w;
        q.push_back(exp_word(w));
        tick();
        start = 1'b0;
    endtask

    initial begin
        // reset state
        sys_rstn = 1'b0;
        repeat (3) tick();
        chk("reset_outs", 32'({busy, done, dac_csn, dac_sclk, dac_sdi, dac_ldacn}),
            32'b001001);
        sys_rstn = 1'b1;
        repeat (2) tick();

        // single frame A5C3
        send(16'hA5C3);
        watch(160, -1, '0, -1, '0);
        chk("f1_busy_first", 32'(first_busy), 32'd1);
        chk("f1_busy_last", 32'(last_busy), 32'd140);
        chk("f1_csn_low", 32'(n_csn), 32'd132);
        chk("f1_ldac_low", 32'(n_ldac), 32'd4);
        chk("f1_done_cnt", 32'(n_done), 32'd1);
        chk("f1_done_at", 32'(done1), 32'd140);

        // back-to-back: 5555 overwritten by 7777 in the pending slot
        start = 1'b1;
        pos_dac = 16'h1234;
        q.push_back(exp_word(16'h1234));
        q.push_back(exp_word(16'h7777));
        tick();
        watch(300, 10, 16'h5555, 50, 16'h7777);
        chk("b2b_done_cnt", 32'(n_done), 32'd2);
        chk("b2b_done1", 32'(done1), 32'd140);
        chk("b2b_done2", 32'(done2c), 32'd280);
        chk("b2b_setup_next", 32'({bh[141], ch[141]}), 32'b10);
        chk("b2b_busy_cnt", 32'(n_busy), 32'd280);
        chk("b2b_csn_low", 32'(n_csn), 32'd264);
        chk("b2b_sb_drained", 32'(q.size()), 32'd0);

        // start in the GAP exit cycle
        start = 1'b1;
        pos_dac = 16'h3C3C;
        q.push_back(exp_word(16'h3C3C));
        q.push_back(exp_word(16'hFFFF));
        tick();
        watch(300, 140, 16'hFFFF, -1, '0);
        chk("gap_no_idle", 32'({bh[141], ch[141]}), 32'b10);
        chk("gap_done2", 32'(done2c), 32'd280);
        chk("gap_sb_drained", 32'(q.size()), 32'd0);

        // reset during bit 7
        send(16'h5AA5);
        repeat (70) tick();
        sys_rstn = 1'b0;
        #1;
        chk("abort_outs", 32'({busy, done, dac_csn, dac_sclk, dac_ldacn}),
            32'b00101);
        q.delete();
        tick();
        sys_rstn = 1'b1;
        watch(40, -1, '0, -1, '0);
        chk("abort_quiet", 32'({n_ldac[7:0], n_done[7:0], n_busy[7:0]}), 32'd0);
        send(16'h0001);
        watch(160, -1, '0, -1, '0);
        chk("abort_resend_done", 32'(done1), 32'd140);
        chk("abort_sb_drained", 32'(q.size()), 32'd0);

        // clamp boundary words
        send(16'h0005);
        watch(150, -1, '0, -1, '0);
        send(16'h8000);
        watch(150, -1, '0, -1, '0);
        send(16'hFFFF);
        watch(150, -1, '0, -1, '0);
        chk("clamp_sb_drained", 32'(q.size()), 32'd0);

        // CLK_DIV=2 instance
        start2 = 1'b1;
        pos_dac2 = 16'h6A5A;
        q2.push_back(16'h6A5A);
        tick();
        start2 = 1'b0;
        n_busy = 0; done1 = -1; last_busy = -1;
        for (int c = 1; c <= 100; c++) begin
            if (busy2) begin
                n_busy++;
                last_busy = c;
            end
            if (done2 && done1 < 0) done1 = c;
            tick();
        end
        chk("div2_busy_cnt", 32'(n_busy), 32'd70);
        chk("div2_busy_last", 32'(last_busy), 32'd70);
        chk("div2_done_at", 32'(done1), 32'd70);
        chk("div2_run_cnt", 32'(run_cnt), 32'd30);
        chk("div2_run_minmax", 32'({run_min[15:0], run_max[15:0]}),
            32'h0002_0002);
        chk("div2_sb_drained", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
